serial_operand_feeder: RTL and testbench
========================================

# serial_operand_feeder

Parallel-to-serial front end for the bit-serial adder datapath. Accepts two WIDTH-bit operands per valid/ready handshake and streams them out LSB-first, one bit pair per clock, with framing strobes. The downstream serial adder uses `out_first` to clear its carry. A one-word holding buffer lets back-to-back operands stream with no idle cycle between words.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2..32.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_in`  in  WIDTH  operand A, parallel.
- `b_in`  in  WIDTH  operand B, parallel.
- `in_valid`  in  1  operand pair on `a_in`/`b_in` is valid.
- `in_ready`  out  1  feeder can accept a pair this cycle.
- `out_a`  out  1  current serial bit of A.
- `out_b`  out  1  current serial bit of B.
- `out_valid`  out  1  `out_a`/`out_b` carry a live bit.
- `out_first`  out  1  current bit is bit 0 of a word; downstream clears its carry.
- `out_last`  out  1  current bit is bit WIDTH-1 of a word.

## Operation
- Transfer: `in_valid && in_ready` at a rising edge.
- Storage:
  - Shifter: `sh_a`, `sh_b`, bit counter `cnt` (0..WIDTH-1), state IDLE/SHIFT.
  - Pending buffer: `pd_a`, `pd_b`, flag `pd_full`.
- `in_ready = !pd_full`. Combinational; no dependency on `in_valid`.
- On an accepted pair, the destination is chosen as follows:
  - State IDLE: load the shifter directly, `cnt`<=0, state<=SHIFT.
  - State SHIFT with `cnt==WIDTH-1` and `!pd_full`: load the shifter directly (seamless restart), `cnt`<=0.
  - Otherwise: write the pending buffer, `pd_full`<=1.
- Each cycle in SHIFT: shift `sh_a`/`sh_b` right by one and increment `cnt`.
- When `cnt==WIDTH-1`:
  - If `pd_full`: move pending to the shifter, `pd_full`<=0, `cnt`<=0, stay in SHIFT.
  - Else, with no direct load: state<=IDLE.
- Outputs are taken from the registered shifter state:
  - `out_a`=`sh_a[0]`, `out_b`=`sh_b[0]`.
  - `out_valid` = (state==SHIFT).
  - `out_first` = SHIFT && `cnt==0`.
  - `out_last` = SHIFT && `cnt==WIDTH-1`.
- In IDLE, `out_a`, `out_b`, `out_first` and `out_last` are forced to 0.
- No output backpressure. The downstream stage consumes one bit per clock unconditionally.
- Operands are unsigned bit vectors; the feeder does no arithmetic and no sign extension.

## Timing
- Reset values: state IDLE, `cnt`=0, `pd_full`=0, shifters 0. Outputs are all 0 except `in_ready`=1.
- Reset is asynchronous: outputs drop on `rst` assertion, not at the next edge.
- Reset mid-word discards both the in-flight word and the pending word. No partial word is emitted after release.
- Latency: pair accepted at edge k → bit 0 visible in the cycle after edge k, with `out_first`=1. Bit WIDTH-1 is visible WIDTH-1 cycles later, with `out_last`=1.
- Throughput: one word per WIDTH cycles. `out_valid` stays continuously high across back-to-back words.
- `in_ready` drops the cycle after a pair lands in the pending buffer. It rises again the cycle after the pending buffer drains into the shifter.
- Simultaneous events:
  - Accept during the `out_last` cycle with `pd_full`=0: the new word goes straight to the shifter, giving zero gap.
  - With `pd_full`=1, `in_ready`=0, so no accept is possible that cycle.
- Holding `in_valid` with `in_ready` low loses no data. Operands must remain stable until the transfer completes.

## Structure
- Package `serial_pkg`:
  - typedef `feeder_state_t` {IDLE, SHIFT}.
  - Function for counter width, `$clog2(WIDTH)`, shared with the serial adder's bench.
- Sub-module `piso_shift_reg` (WIDTH param; load, shift, q[0]): instantiated twice, once for A and once for B.
- The pending buffer and FSM live in the top module.

## Test plan
- Single word, WIDTH=8, a=0x0D, b=0x0B after reset → cycles 1..8:
  - `out_a` = 1,0,1,1,0,0,0,0 and `out_b` = 1,1,0,1,0,0,0,0.
  - `out_first` in cycle 1, `out_last` in cycle 8; `out_valid` low in cycle 9.
- Back-to-back: three pairs (0xFF/0x01, 0x80/0x80, 0x55/0xAA) with `in_valid` held high → 24 contiguous valid cycles with `out_first` every 8 cycles. `in_ready` is low only while the pending buffer is full.
- Accept exactly on the `out_last` cycle with an empty pending buffer → the next cycle shows the new word's bit 0, `out_first`=1, no gap.
- Backpressure: `in_valid` held continuously → `in_ready`=0 for 7 of every 8 cycles in steady state. Every pair is emitted exactly once, in order.
- Reset mid-operation: assert `rst` at bit 3 with a pending word → all outputs 0 immediately and `in_ready`=1. After release, `out_valid` stays 0 until a new accept.
- End to end with `serial_adder` fed by `out_a`/`out_b` (carry cleared on `out_first`): 0x0D + 0x0B → serial sum bits 0,0,0,1,1,0,0,0 (0x18).

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the bit-serial datapath.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } feeder_state_t;

    // Width of a bit counter that indexes 0..width-1. It is at least 1 so the
    // counter is never zero-width.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB first. Load has priority over shift.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);

    logic [WIDTH-1:0] sh_d, sh_q;

    // Next value: a parallel load replaces the word; a shift moves it one bit toward bit 0.
    always_comb begin
        sh_d = sh_q;
        if (load)
            sh_d = d;
        else if (shift)
            sh_d = {1'b0, sh_q[WIDTH-1:1]};
    end

    // Shifter register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sh_q <= '0;
        else
            sh_q <= sh_d;
    end

    assign q0 = sh_q[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand feeder. Streams A/B pairs LSB-first with framing
// strobes. A one-word pending buffer keeps back-to-back words gapless.
module serial_operand_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_a,
    output logic             out_b,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    feeder_state_t    state_d, state_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic [WIDTH-1:0] pd_a_d, pd_a_q, pd_b_d, pd_b_q;
    logic             pd_full_d, pd_full_q;

    logic             accept;
    logic             at_last;
    logic             sh_load, sh_load_pd, sh_shift;
    logic [WIDTH-1:0] ld_a, ld_b;
    logic             q0_a, q0_b;

    assign in_ready = !pd_full_q;
    assign accept   = in_valid && !pd_full_q;
    assign at_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // Next state: pick where an accepted pair goes and when the shifter reloads.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pd_a_d     = pd_a_q;
        pd_b_d     = pd_b_q;
        pd_full_d  = pd_full_q;
        sh_load    = 1'b0;
        sh_load_pd = 1'b0;
        sh_shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_load = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    if (pd_full_q) begin
                        // The pending word follows with no gap; in_ready is low so nothing new arrives.
                        sh_load    = 1'b1;
                        sh_load_pd = 1'b1;
                        pd_full_d  = 1'b0;
                        cnt_d      = '0;
                    end else if (accept) begin
                        // Seamless restart straight from the inputs.
                        sh_load = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    sh_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (accept) begin
                        pd_a_d    = a_in;
                        pd_b_d    = b_in;
                        pd_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and pending-buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pd_a_q    <= '0;
            pd_b_q    <= '0;
            pd_full_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pd_a_q    <= pd_a_d;
            pd_b_q    <= pd_b_d;
            pd_full_q <= pd_full_d;
        end
    end

    assign ld_a = sh_load_pd ? pd_a_q : a_in;
    assign ld_b = sh_load_pd ? pd_b_q : b_in;

    piso_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .d     (ld_a),
        .q0    (q0_a)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .d     (ld_b),
        .q0    (q0_b)
    );

    // All serial outputs come from registered state and are quiet in IDLE.
    assign out_valid = (state_q == SHIFT);
    assign out_a     = out_valid && q0_a;
    assign out_b     = out_valid && q0_b;
    assign out_first = out_valid && (cnt_q == '0);
    assign out_last  = at_last;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench for serial_operand_feeder: framing, gapless streaming,
// backpressure, reset mid-word, and a serial-adder model on the outputs.
module tb_serial_operand_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_in, b_in;
    logic         in_valid, in_ready;
    logic         out_a, out_b, out_valid, out_first, out_last;

    serial_operand_feeder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
    } word_t;

    word_t        rcv[$];
    logic [W-1:0] ca, cb, cs;
    logic         cy;
    int           bp, run, max_run, rdy_lo, frame_err;
    logic         acc;
    logic [W-1:0] sa[8];
    logic [W-1:0] sb[8];

    // Sample this cycle's outputs into the word collector / serial adder model,
    // note the handshake, then advance to 1ns past the next rising edge.
    task automatic cyc();
        if (out_valid) begin
            if (out_first) begin
                bp = 0; cy = 1'b0; ca = '0; cb = '0; cs = '0;
            end
            if (bp < W) begin
                ca[bp] = out_a;
                cb[bp] = out_b;
                cs[bp] = out_a ^ out_b ^ cy;
            end
            cy = (out_a & out_b) | (cy & (out_a ^ out_b));
            if (out_last) begin
                if (bp != W - 1) frame_err++;
                rcv.push_back('{ca, cb, cs});
            end
            bp++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (!in_ready) rdy_lo++;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        rcv.delete();
        run = 0; max_run = 0; rdy_lo = 0; frame_err = 0; bp = W;
    endtask

    // Offer sa/sb[0..n-1] with in_valid held high, then drain.
    task automatic run_stream(input int n);
        int idx = 0;
        clr_stats();
        for (int t = 0; t < 300 && (idx < n || out_valid || t == 0); t++) begin
            in_valid = (idx < n);
            a_in     = sa[(idx < n) ? idx : 0];
            b_in     = sb[(idx < n) ? idx : 0];
            cyc();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("stream_complete", {31'd0, (idx == n && !out_valid)}, 32'd1);
    endtask

    logic [W-1:0] fp, lp, vp;

    initial begin
        rst = 1'b1; a_in = '0; b_in = '0; in_valid = 1'b0;
        clr_stats();
        #2;
        chk("rst_outs", {27'd0, out_a, out_b, out_valid, out_first, out_last}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        chk("post_rst_idle", {30'd0, out_valid, in_ready}, 32'd1);

        // Single word 0x0D / 0x0B
        clr_stats();
        a_in = 8'h0D; b_in = 8'h0B; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            fp[i] = out_first; lp[i] = out_last; vp[i] = out_valid;
            cyc();
        end
        chk("single_first", {24'd0, fp}, 32'h01);
        chk("single_last", {24'd0, lp}, 32'h80);
        chk("single_valid", {24'd0, vp}, 32'hFF);
        chk("single_c9_valid", {31'd0, out_valid}, 32'd0);
        chk("single_c9_outs", {29'd0, out_a, out_b, out_first}, 32'd0);
        chk("single_nwords", rcv.size(), 32'd1);
        if (rcv.size() >= 1) begin
            chk("single_a", {24'd0, rcv[0].a}, 32'h0D);
            chk("single_b", {24'd0, rcv[0].b}, 32'h0B);
            chk("adder_sum", {24'd0, rcv[0].s}, 32'h18);
        end

        // Back-to-back: three pairs
        sa[0] = 8'hFF; sb[0] = 8'h01;
        sa[1] = 8'h80; sb[1] = 8'h80;
        sa[2] = 8'h55; sb[2] = 8'hAA;
        run_stream(3);
        chk("b2b_nwords", rcv.size(), 32'd3);
        chk("b2b_run", max_run, 32'd24);
        chk("b2b_ready_lo", rdy_lo, 32'd14);
        chk("b2b_framing", frame_err, 32'd0);
        for (int i = 0; i < 3 && i < rcv.size(); i++) begin
            chk($sformatf("b2b_w%0d", i), {16'd0, rcv[i].a, rcv[i].b}, {16'd0, sa[i], sb[i]});
        end

        // Accept exactly in the out_last cycle with the pending buffer empty
        clr_stats();
        a_in = 8'h3C; b_in = 8'hC3; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int t = 0; t < 20 && !out_last; t++) cyc();
        chk("lastacc_found", {31'd0, out_last}, 32'd1);
        chk("lastacc_ready", {31'd0, in_ready}, 32'd1);
        a_in = 8'h01; b_in = 8'h02; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("lastacc_next", {28'd0, out_valid, out_first, out_a, out_b}, 32'b1110);
        for (int t = 0; t < 20 && out_valid; t++) cyc();
        chk("lastacc_run", max_run, 32'd16);
        chk("lastacc_nwords", rcv.size(), 32'd2);
        if (rcv.size() >= 2)
            chk("lastacc_w1", {16'd0, rcv[1].a, rcv[1].b}, 32'h0102);

        // Sustained backpressure: five pairs offered continuously
        sa[0] = 8'h12; sb[0] = 8'h34;
        sa[1] = 8'hA5; sb[1] = 8'h5A;
        sa[2] = 8'h00; sb[2] = 8'hFF;
        sa[3] = 8'h81; sb[3] = 8'h7E;
        sa[4] = 8'hC9; sb[4] = 8'h36;
        run_stream(5);
        chk("bp_nwords", rcv.size(), 32'd5);
        chk("bp_run", max_run, 32'd40);
        chk("bp_ready_lo", rdy_lo, 32'd28);
        for (int i = 0; i < 5 && i < rcv.size(); i++) begin
            chk($sformatf("bp_w%0d", i), {16'd0, rcv[i].a, rcv[i].b}, {16'd0, sa[i], sb[i]});
        end

        // Reset at bit 3 with a pending word
        clr_stats();
        a_in = 8'hFF; b_in = 8'hFF; in_valid = 1'b1;
        cyc();
        a_in = 8'h5A; b_in = 8'hA5;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("mid_pending", {30'd0, in_ready, out_a}, 32'b01);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {27'd0, out_a, out_b, out_valid, out_first, out_last}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr_stats();
        for (int t = 0; t < 12; t++) cyc();
        chk("after_rst_quiet", max_run, 32'd0);
        chk("after_rst_nwords", rcv.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
